// File: rtl/tensor_core_pkg.sv
// Shared types and defaults for the tensor core vocab path.
// Holds the arbiter FSM state enum and default vocab SRAM geometry.
package tensor_core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_LOCKED
  } arb_state_t;

  localparam int VOCAB_ADDR_W = 4;
  localparam int VOCAB_DATA_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// searching upward modulo N. Returns one-hot pick, its index and any.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk from farthest to nearest so the closest requester wins.
  always_comb begin
    int j;
    j    = 0;
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      j = (int'(ptr) + off) % N;
      if (req[j]) begin
        pick    = '0;
        pick[j] = 1'b1;
        idx     = IW'(j);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vocab_port_arbiter.sv
// Round-robin arbiter sharing one sync-read vocab SRAM among NUM_REQ lanes.
// Optional burst locking is built only when VOCAB_ARB_LOCK_EN is defined.
module vocab_port_arbiter
  import tensor_core_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = VOCAB_ADDR_W,
  parameter int DATA_WIDTH = VOCAB_DATA_W,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_cs,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_dout
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] tag_q;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] tag_oh;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic valid_q;
  logic pick_any;
  logic hold;

`ifdef VOCAB_ARB_LOCK_EN
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CW-1:0] burst_q, burst_d;
  logic others;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] k);
    return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign tag_oh = NUM_REQ'(1) << tag_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt      = pick;
    gnt_idx  = pick_idx;
`ifdef VOCAB_ARB_LOCK_EN
    burst_d  = burst_q;
    others   = |(req & ~tag_oh);
    hold     = (state_q == ARB_LOCKED) && req[tag_q] && lock[tag_q];
`else
    hold     = 1'b0;
`endif
    if (hold) begin
      gnt     = tag_oh;
      gnt_idx = tag_q;
`ifdef VOCAB_ARB_LOCK_EN
      // Last permitted burst grant: hand the pointer past the holder.
      if (burst_q == CW'(MAX_BURST - 1)) begin
        if (others) begin
          rr_ptr_d = rr_next(tag_q);
          state_d  = ARB_GRANT;
          burst_d  = '0;
        end
      end else begin
        burst_d = burst_q + 1'b1;
      end
`endif
    end else if (pick_any) begin
      rr_ptr_d = rr_next(pick_idx);
      state_d  = ARB_GRANT;
`ifdef VOCAB_ARB_LOCK_EN
      if (lock[pick_idx]) begin
        state_d = ARB_LOCKED;
        burst_d = CW'(1);
      end
`endif
    end else begin
      state_d = ARB_IDLE;
    end
  end

  assign mem_cs   = |gnt;
  assign mem_addr = mem_cs ? addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]
                           : addr_q;

  // SRAM output is already one cycle behind cs; gate it by the tag.
  assign rvalid = valid_q ? tag_oh : '0;
  assign rdata  = valid_q ? mem_dout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= mem_cs;
      if (mem_cs) begin
        tag_q  <= gnt_idx;
        addr_q <= mem_addr;
      end
    end
  end

`ifdef VOCAB_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_q <= '0;
    else     burst_q <= burst_d;
  end
`endif

endmodule

// File: tb/tb_vocab_port_arbiter.sv
// Directed bench for vocab_port_arbiter with a behavioural vocab SRAM.
// Lock-mode expectations follow VOCAB_ARB_LOCK_EN.
module tb_vocab_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rvalid;
  logic [DW-1:0] rdata;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;

  int n_cmp = 0;
  int n_bad = 0;

  vocab_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_cs(mem_cs),
    .mem_addr(mem_addr), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] vocab(input logic [AW-1:0] a);
    logic [7:0] v;
    v = {4'h0, a};
    return (v * 8'd29) ^ 8'h3C;
  endfunction

  always @(posedge clk) if (mem_cs) mem_dout <= vocab(mem_addr);

  task automatic set_addr(input int lane, input logic [AW-1:0] a);
    addr[lane*AW +: AW] = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; lock = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL rst_gnt got %b want 0", gnt); end
    n_cmp++; if (rvalid !== 4'b0) begin n_bad++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
    n_cmp++; if (rdata !== 8'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", rdata); end
    n_cmp++; if (mem_cs !== 1'b0) begin n_bad++; $display("FAIL rst_cs got %b want 0", mem_cs); end
    n_cmp++; if (mem_addr !== 4'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 4'b0001; set_addr(0, 4'd3);
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got %b want 0001", gnt); end
    n_cmp++; if (mem_addr !== 4'd3) begin n_bad++; $display("FAIL single_addr got %h want 3", mem_addr); end
    n_cmp++; if (mem_cs !== 1'b1) begin n_bad++; $display("FAIL single_cs got %b want 1", mem_cs); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    n_cmp++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL single_rvalid got %b want 0001", rvalid); end
    n_cmp++; if (rdata !== vocab(4'd3)) begin n_bad++; $display("FAIL single_rdata got %h want %h", rdata, vocab(4'd3)); end
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL idle_gnt got %b want 0", gnt); end
    n_cmp++; if (mem_cs !== 1'b0) begin n_bad++; $display("FAIL idle_cs got %b want 0", mem_cs); end
    n_cmp++; if (mem_addr !== 4'd3) begin n_bad++; $display("FAIL idle_addr_hold got %h want 3", mem_addr); end
    @(negedge clk);
    #1;
    n_cmp++; if (rvalid !== 4'b0) begin n_bad++; $display("FAIL idle_rvalid got %b want 0", rvalid); end
  endtask

  task automatic test_rotation();
    logic [N-1:0] eg, er;
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, AW'(4 + i));
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        eg = 4'b0001 << (c % 4);
        n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL rot_gnt c=%0d got %b want %b", c, gnt, eg); end
        n_cmp++; if (mem_addr !== AW'(4 + c % 4)) begin n_bad++; $display("FAIL rot_addr c=%0d got %h want %h", c, mem_addr, 4 + c % 4); end
      end
      if (c > 0) begin
        er = 4'b0001 << ((c - 1) % 4);
        n_cmp++; if (rvalid !== er) begin n_bad++; $display("FAIL rot_rvalid c=%0d got %b want %b", c, rvalid, er); end
        n_cmp++; if (rdata !== vocab(AW'(4 + (c - 1) % 4))) begin n_bad++; $display("FAIL rot_rdata c=%0d got %h", c, rdata); end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_addr(2, 4'd9); set_addr(3, 4'd10); set_addr(0, 4'd11);
    @(negedge clk);
    req = 4'b0100;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL wrap_pre got %b want 0100", gnt); end
    @(negedge clk);
    req = 4'b1001;
    #1;
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_gnt3 got %b want 1000", gnt); end
    n_cmp++; if (rvalid !== 4'b0100) begin n_bad++; $display("FAIL wrap_rv2 got %b want 0100", rvalid); end
    @(negedge clk);
    req = 4'b0001;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt0 got %b want 0001", gnt); end
    n_cmp++; if (rdata !== vocab(4'd10)) begin n_bad++; $display("FAIL wrap_rd3 got %h want %h", rdata, vocab(4'd10)); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    n_cmp++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL wrap_rv0 got %b want 0001", rvalid); end
    n_cmp++; if (rdata !== vocab(4'd11)) begin n_bad++; $display("FAIL wrap_rd0 got %h want %h", rdata, vocab(4'd11)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_addr(2, 4'd5);
    @(negedge clk);
    req = 4'b0100;
    #1;
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL arst_gnt got %b want 0100", gnt); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    n_cmp++; if (rvalid !== 4'b0100) begin n_bad++; $display("FAIL arst_pre_rv got %b want 0100", rvalid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rvalid !== 4'b0) begin n_bad++; $display("FAIL arst_rvalid got %b want 0", rvalid); end
    n_cmp++; if (rdata !== 8'h0) begin n_bad++; $display("FAIL arst_rdata got %h want 0", rdata); end
    n_cmp++; if (mem_addr !== 4'h0) begin n_bad++; $display("FAIL arst_addr got %h want 0", mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    #1;
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL arst_first got %b want 0001", gnt); end
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic test_lock();
    logic [N-1:0] exp_g [8];
`ifdef VOCAB_ARB_LOCK_EN
    exp_g = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h2, 4'h2, 4'h2};
`else
    exp_g = '{4'h2, 4'h4, 4'h2, 4'h4, 4'h2, 4'h4, 4'h2, 4'h4};
`endif
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req = 4'b0110; lock = 4'b0010;
      #1;
      n_cmp++; if (gnt !== exp_g[c]) begin n_bad++; $display("FAIL lock_gnt c=%0d got %b want %b", c, gnt, exp_g[c]); end
    end
    @(negedge clk);
    req = '0; lock = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] pg, g;
    logic [AW-1:0] pa;
    int wt [N];
    do_reset();
    pg = '0; pa = '0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_cmp++; if (rvalid !== pg) begin n_bad++; $display("FAIL rnd_rvalid c=%0d got %b want %b", c, rvalid, pg); end
      if (pg != 0) begin
        n_cmp++; if (rdata !== vocab(pa)) begin n_bad++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, rdata, vocab(pa)); end
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] || pg[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          set_addr(i, AW'($urandom));
        end
      end
      #1;
      g = gnt;
      n_cmp++; if (!$onehot0(g) || (g & ~req) != 0) begin n_bad++; $display("FAIL rnd_onehot c=%0d gnt %b req %b", c, g, req); end
      n_cmp++; if ((req != 0) !== (g != 0)) begin n_bad++; $display("FAIL rnd_idle c=%0d gnt %b req %b", c, g, req); end
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          n_cmp++; if (mem_addr !== addr[i*AW +: AW]) begin n_bad++; $display("FAIL rnd_addr c=%0d got %h want %h", c, mem_addr, addr[i*AW +: AW]); end
          pa = addr[i*AW +: AW];
        end
        wt[i] = (req[i] && !g[i]) ? wt[i] + 1 : 0;
        if (wt[i] > N - 1) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd_wait lane %0d waited %0d want <= %0d", i, wt[i], N - 1);
          wt[i] = 0;
        end
      end
      pg = g;
    end
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_async_reset();
    test_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
